diff_scan_unit: RTL and testbench



---
 rtl/diff_pkg.sv | 20 ++
 rtl/diff_chunk_scan.sv | 34 +++
 rtl/diff_scan_unit.sv | 179 +++++++++++++++++
 tb/tb_diff_scan_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_pkg.sv
// -----------------------------------------------------------------------------
// diff_pkg
// Shared encodings for the multi-cycle bit-difference unit.
//   MODE_*  : operation select presented on the unit's mode port
//   state_t : controller states (idle, chunk scan, result pulse)
// -----------------------------------------------------------------------------
package diff_pkg;

  // Operation select; the unused code 2'd3 is handled as MODE_LOW.
  localparam logic [1:0] MODE_LOW   = 2'd0;
  localparam logic [1:0] MODE_HIGH  = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/diff_chunk_scan.sv
// -----------------------------------------------------------------------------
// diff_chunk_scan
// Purely combinational examination of one CHUNK-bit slice of the difference
// word.
//   chunk   in   CHUNK bits  slice under examination
//   any     out  1           slice has at least one set bit
//   low_pos out  LPW bits    position of the lowest set bit (0 if none)
//   pop     out  PW bits     number of set bits in the slice
// -----------------------------------------------------------------------------
module diff_chunk_scan #(
  parameter  int CHUNK = 8,
  localparam int LPW   = (CHUNK > 1) ? $clog2(CHUNK) : 1,
  localparam int PW    = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] chunk,
  output logic             any,
  output logic [LPW-1:0]   low_pos,
  output logic [PW-1:0]    pop
);

  always_comb begin
    any     = |chunk;
    low_pos = '0;
    pop     = '0;
    // Walk from the top down so the lowest set bit is the last one written.
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) low_pos = LPW'(i);
    end
    for (int i = 0; i < CHUNK; i++) begin
      pop = pop + PW'(chunk[i]);
    end
  end

endmodule

// File: rtl/diff_scan_unit.sv
// -----------------------------------------------------------------------------
// diff_scan_unit
// Multi-cycle bit-difference unit. On an accepted request it latches
// input1^input2 (bit-reversed for HIGH mode) and scans it CHUNK bits per clock,
// producing the lowest differing index, the highest differing index, or the
// Hamming distance after a fixed NCHUNK scan cycles.
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   start    in   1      request, taken only when ready=1
//   mode     in   2      0=LOW, 1=HIGH, 2=COUNT, 3 behaves as LOW
//   input1   in   WIDTH  operand A (sampled on the accepting edge only)
//   input2   in   WIDTH  operand B (sampled on the accepting edge only)
//   ready    out  1      idle, able to accept
//   done     out  1      one-cycle pulse, result valid
//   found    out  1      operands differed in at least one bit
//   output1  out  RW     index or count; WIDTH means "no differing bit"
// WIDTH must be a multiple of CHUNK and CHUNK a power of two.
// -----------------------------------------------------------------------------
module diff_scan_unit
  import diff_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int RW     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             ready,
  output logic             done,
  output logic             found,
  output logic [RW-1:0]    output1
);

  localparam int KW  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LPW = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int PW  = $clog2(CHUNK) + 1;

  // Controller / operand state
  state_t             r_state;
  logic [1:0]         r_mode;
  logic [WIDTH-1:0]   r_d;
  logic [KW-1:0]      r_k;
  logic [RW-1:0]      r_acc;
  logic [RW-1:0]      r_idx;
  logic               r_hit;
  logic               r_ready;
  logic               r_done;
  logic               r_found;
  logic [RW-1:0]      r_out;

  // Combinational helpers
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_diff_rev;
  logic [CHUNK-1:0]   w_chunk;
  logic               w_any;
  logic [LPW-1:0]     w_low_pos;
  logic [PW-1:0]      w_pop;
  logic               w_hit_next;
  logic [RW-1:0]      w_idx_next;
  logic [RW-1:0]      w_acc_next;
  logic               w_last;
  logic [RW-1:0]      w_result;
  logic               w_found_res;

  assign w_diff = input1 ^ input2;

  // HIGH mode reuses the lowest-bit search on the mirrored word; the index is
  // mapped back with WIDTH-1-idx when the result is formed.
  always_comb begin
    w_diff_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_diff_rev[i] = w_diff[WIDTH-1-i];
    end
  end

  assign w_chunk = r_d[r_k*CHUNK +: CHUNK];

  diff_chunk_scan #(
    .CHUNK (CHUNK)
  ) u_chunk_scan (
    .chunk   (w_chunk),
    .any     (w_any),
    .low_pos (w_low_pos),
    .pop     (w_pop)
  );

  // Next accumulator values including the chunk processed on this edge, so the
  // final result can be registered on the very edge that scans the last chunk.
  always_comb begin
    w_hit_next = r_hit | w_any;
    w_idx_next = r_idx;
    if (!r_hit) begin
      w_idx_next = RW'(r_k) * RW'(CHUNK) + RW'(w_low_pos);
    end
    w_acc_next = r_acc + RW'(w_pop);
    w_last     = (r_k == KW'(NCHUNK - 1));

    case (r_mode)
      MODE_COUNT: begin
        w_result    = w_acc_next;
        w_found_res = (w_acc_next != '0);
      end
      MODE_HIGH: begin
        w_result    = w_hit_next ? (RW'(WIDTH - 1) - w_idx_next) : RW'(WIDTH);
        w_found_res = w_hit_next;
      end
      default: begin
        w_result    = w_hit_next ? w_idx_next : RW'(WIDTH);
        w_found_res = w_hit_next;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_out   <= '0;
      r_k     <= '0;
      r_hit   <= 1'b0;
    end else begin
      case (r_state)
        // Accept: capture the difference word and clear the scan state
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_d     <= (mode == MODE_HIGH) ? w_diff_rev : w_diff;
            r_mode  <= mode;
            r_acc   <= '0;
            r_idx   <= '0;
            r_hit   <= 1'b0;
            r_k     <= '0;
            r_ready <= 1'b0;
            r_state <= S_SCAN;
          end
        end
        // Scan: one chunk per edge, fixed count, no early exit
        S_SCAN: begin
          r_acc <= w_acc_next;
          r_idx <= w_idx_next;
          r_hit <= w_hit_next;
          if (w_last) begin
            r_k     <= '0;
            r_out   <= w_result;
            r_found <= w_found_res;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        // Result pulse, then back to idle unconditionally
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign done    = r_done;
  assign found   = r_found;
  assign output1 = r_out;

endmodule

// File: tb/tb_diff_scan_unit.sv
// -----------------------------------------------------------------------------
// tb_diff_scan_unit
// Two instances (32/8 and 64/16) driven from one clock. A cycle-level reference
// model computes the expected ready/done/found/output1 from the operation rules
// and a negedge monitor compares them every cycle; directed operations add
// literal expectations.
// -----------------------------------------------------------------------------
module tb_diff_scan_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r32 = 1'b1, s32 = 1'b0;
  logic [1:0]  m32 = 2'd0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        rdy32, dn32, f32;
  logic [5:0]  o32;

  logic        r64 = 1'b1, s64 = 1'b0;
  logic [1:0]  m64 = 2'd0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        rdy64, dn64, f64;
  logic [6:0]  o64;

  diff_scan_unit #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(r32), .start(s32), .mode(m32), .input1(a32), .input2(b32),
    .ready(rdy32), .done(dn32), .found(f32), .output1(o32)
  );

  diff_scan_unit #(.WIDTH(64), .CHUNK(16)) dut64 (
    .clk(clk), .rst(r64), .start(s64), .mode(m64), .input1(a64), .input2(b64),
    .ready(rdy64), .done(dn64), .found(f64), .output1(o64)
  );

  int tests = 0;
  int fails = 0;
  bit seq_done = 1'b0;

  // Expected result straight from the operation rules.
  function automatic int ref_out(input logic [63:0] d, input logic [1:0] m, input int w);
    int r;
    if (m == 2'd2) return $countones(d);
    r = w;
    if (m == 2'd1) begin
      for (int i = 0; i < w; i++) if (d[i]) r = i;
    end else begin
      for (int i = w - 1; i >= 0; i--) if (d[i]) r = i;
    end
    return r;
  endfunction

  // Cycle-level model state per instance: edges left until idle.
  int m_left[2];
  int e_out[2];
  bit e_found[2];
  int p_out[2];
  bit p_found[2];
  bit m_valid[2];

  task automatic model_step(input int id, input logic r, input logic s, input logic [1:0] m,
                            input logic [63:0] d, input int w, input int n);
    if (r) begin
      m_left[id]  = 0;
      e_out[id]   = 0;
      e_found[id] = 1'b0;
      m_valid[id] = 1'b1;
    end else if (m_left[id] == 0) begin
      if (s) begin
        p_out[id]   = ref_out(d, m, w);
        p_found[id] = (d != 64'd0);
        m_left[id]  = n + 1;
      end
    end else begin
      m_left[id] = m_left[id] - 1;
      if (m_left[id] == 1) begin
        e_out[id]   = p_out[id];
        e_found[id] = p_found[id];
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, r32, s32, m32, {32'd0, a32 ^ b32}, 32, 4);
    model_step(1, r64, s64, m64, a64 ^ b64, 64, 4);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    while (!seq_done) begin
      @(negedge clk);
      if (m_valid[0]) begin
        chk("ready32", int'(rdy32), int'(m_left[0] == 0));
        chk("done32",  int'(dn32),  int'(m_left[0] == 1));
        chk("found32", int'(f32),   int'(e_found[0]));
        chk("out32",   int'(o32),   e_out[0]);
      end
      if (m_valid[1]) begin
        chk("ready64", int'(rdy64), int'(m_left[1] == 0));
        chk("done64",  int'(dn64),  int'(m_left[1] == 1));
        chk("found64", int'(f64),   int'(e_found[1]));
        chk("out64",   int'(o64),   e_out[1]);
      end
    end
  endtask

  // One operation: wait for ready, pulse start, wait for done (bounded).
  task automatic op(input int id, input logic [63:0] a, input logic [63:0] b,
                    input logic [1:0] m, input bit lit, input int eout, input bit efound,
                    input string name);
    int n;
    n = 0;
    while (!(id == 1 ? rdy64 : rdy32) && n < 20) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 20) chk({name, "_ready_timeout"}, 0, 1);
    if (id == 0) begin
      a32 = a[31:0]; b32 = b[31:0]; m32 = m; s32 = 1'b1;
    end else begin
      a64 = a; b64 = b; m64 = m; s64 = 1'b1;
    end
    @(posedge clk); #2;
    s32 = 1'b0; s64 = 1'b0;
    n = 0;
    while (!(id == 1 ? dn64 : dn32) && n < 20) begin
      @(posedge clk); #2; n++;
    end
    chk({name, "_latency"}, n, 4);
    if (lit) begin
      chk({name, "_out"},   (id == 1) ? int'(o64) : int'(o32), eout);
      chk({name, "_found"}, (id == 1) ? int'(f64) : int'(f32), int'(efound));
    end
  endtask

  task automatic main_seq();
    int n;
    bit seen;
    logic [63:0] ra, rb;
    int w;

    // Pin the reference model with hand-computed values
    chk("ref_low",   ref_out(64'h0000_00E0, 2'd0, 32), 5);
    chk("ref_high",  ref_out(64'h8000_0001, 2'd1, 32), 31);
    chk("ref_count", ref_out(64'hA5A5_0000, 2'd2, 32), 8);
    chk("ref_eq",    ref_out(64'd0, 2'd1, 32), 32);
    chk("ref_b63",   ref_out(64'h8000_0000_0000_0000, 2'd0, 64), 63);

    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready32", int'(rdy32), 1);
    chk("rst_out32", int'(o32), 0);
    r32 = 1'b0; r64 = 1'b0;

    op(0, 64'h0000_00F0, 64'h0000_0010, 2'd0, 1, 5, 1, "low_f0");
    op(0, 64'h8000_0001, 64'd0, 2'd1, 1, 31, 1, "high_b31");
    op(0, 64'h8000_0001, 64'd0, 2'd0, 1, 0, 1, "low_b0");
    op(0, 64'hFFFF_FFFF, 64'd0, 2'd2, 1, 32, 1, "count_all");
    op(0, 64'hA5A5_0000, 64'd0, 2'd2, 1, 8, 1, "count_a5");
    op(0, 64'h1234_5678, 64'h1234_5678, 2'd0, 1, 32, 0, "eq_low");
    op(0, 64'h1234_5678, 64'h1234_5678, 2'd1, 1, 32, 0, "eq_high");
    op(0, 64'h1234_5678, 64'h1234_5678, 2'd2, 1, 0, 0, "eq_count");
    op(0, 64'h0000_0100, 64'd0, 2'd3, 1, 8, 1, "mode3_low");

    // start held high (raised while the unit is still busy) with operands churning
    a32 = 32'h0000_0100; b32 = 32'd0; m32 = 2'd0; s32 = 1'b1;
    n = 0;
    while (!rdy32 && n < 20) begin @(posedge clk); #2; n++; end
    seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #2;
      a32 = $urandom; b32 = $urandom; m32 = 2'($urandom_range(0, 3));
      if (dn32 && !seen) begin
        seen = 1'b1;
        chk("hold_out", int'(o32), 8);
        chk("hold_found", int'(f32), 1);
      end
    end
    chk("hold_seen", int'(seen), 1);
    s32 = 1'b0;
    n = 0;
    while (!rdy32 && n < 20) begin @(posedge clk); #2; n++; end

    // Reset on the second scan edge aborts the operation
    op(0, 64'h0000_00F0, 64'h0000_0010, 2'd0, 1, 5, 1, "pre_rst");
    n = 0;
    while (!rdy32 && n < 20) begin @(posedge clk); #2; n++; end
    a32 = 32'hFFFF_0000; b32 = 32'd0; m32 = 2'd2; s32 = 1'b1;
    @(posedge clk); #2;
    s32 = 1'b0;
    @(posedge clk); #2;
    r32 = 1'b1;
    @(posedge clk); #2;
    r32 = 1'b0;
    chk("abort_ready", int'(rdy32), 1);
    chk("abort_out", int'(o32), 0);
    chk("abort_found", int'(f32), 0);
    repeat (6) @(posedge clk);
    #2;
    op(0, 64'hFFFF_FFFF, 64'd0, 2'd2, 1, 32, 1, "post_rst");

    // 64-bit / 16-bit chunk instance
    op(1, 64'h8000_0000_0000_0000, 64'd0, 2'd0, 1, 63, 1, "w64_low63");
    op(1, 64'h8000_0000_0000_0000, 64'd0, 2'd2, 1, 1, 1, "w64_count1");
    op(1, 64'h8000_0000_0000_0000, 64'd0, 2'd1, 1, 63, 1, "w64_high63");
    op(1, 64'h0000_0001_0000_0000, 64'd0, 2'd0, 1, 32, 1, "w64_low32");
    op(1, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 2'd1, 1, 64, 0, "w64_eq");

    // Randomized operations, checked by the monitor against the model
    for (int t = 0; t < 60; t++) begin
      int id;
      id = t % 2;
      w  = (id == 1) ? 64 : 32;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (64'd1 << $urandom_range(0, w - 1));
        2: rb = ra ^ ((64'd1 << $urandom_range(0, w - 1)) | (64'd1 << $urandom_range(0, w - 1)));
        default: ;
      endcase
      op(id, ra, rb, 2'($urandom_range(0, 3)), 0, 0, 0, "rand");
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end

    repeat (8) @(posedge clk);
    #2;
    seq_done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
